hps_avmm_mailbox: RTL and testbench

Parametrised multi-channel mailbox between the HPS lightweight Avalon-MM bridge and the FPGA-side RISC-V core.
- Each channel has one host-to-core FIFO (h2c) and one core-to-host FIFO (c2h), plus status and control registers.
- Host side is an Avalon-MM slave with fixed read latency 1.
- Core side uses valid/ready streams.
- Sits next to soc_system in the top level and shares its clock and reset.

---
 rtl/hps_avmm_mailbox.sv | 207 ++++++++++++++++++++
 tb/tb_hps_avmm_mailbox.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_avmm_mailbox.sv
// Multi-channel HPS <-> RISC-V mailbox: Avalon-MM host side, valid/ready core side.
// Optional host interrupt is built only when HPS_MBOX_IRQ_EN is defined.
module hps_avmm_mailbox #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(CHANNELS) + 2
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [ADDR_WIDTH-1:0]          avs_address,
  input  logic                           avs_read,
  input  logic                           avs_write,
  input  logic [DATA_WIDTH-1:0]          avs_writedata,
  output logic [DATA_WIDTH-1:0]          avs_readdata,
  output logic                           avs_readdatavalid,
  output logic [CHANNELS*DATA_WIDTH-1:0] core_rx_data,
  output logic [CHANNELS-1:0]            core_rx_valid,
  input  logic [CHANNELS-1:0]            core_rx_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] core_tx_data,
  input  logic [CHANNELS-1:0]            core_tx_valid,
  output logic [CHANNELS-1:0]            core_tx_ready,
  output logic                           irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Counts are CNT_W bits wide; the status fields only have room for 8.
  function automatic logic [7:0] sat8(input logic [CNT_W-1:0] cnt);
    if (32'(cnt) > 32'd255) sat8 = 8'hFF;
    else                    sat8 = 8'(cnt);
  endfunction

  logic [DATA_WIDTH-1:0] h2c_mem_r [CHANNELS][DEPTH];
  logic [DATA_WIDTH-1:0] c2h_mem_r [CHANNELS][DEPTH];
  logic [PTR_W-1:0]      h2c_wp_r [CHANNELS];
  logic [PTR_W-1:0]      h2c_rp_r [CHANNELS];
  logic [PTR_W-1:0]      c2h_wp_r [CHANNELS];
  logic [PTR_W-1:0]      c2h_rp_r [CHANNELS];
  logic [CNT_W-1:0]      h2c_cnt_r [CHANNELS];
  logic [CNT_W-1:0]      c2h_cnt_r [CHANNELS];
  logic [CHANNELS-1:0]   ovf_r, unf_r, irq_en_s;

  logic [CHANNELS-1:0] ch_sel_s, h2c_empty_s, h2c_full_s, c2h_empty_s, c2h_full_s;
  logic [CHANNELS-1:0] h2c_push_s, h2c_pop_s, c2h_push_s, c2h_pop_s;
  logic [CHANNELS-1:0] h2c_flush_s, c2h_flush_s, clr_s, ovf_ev_s, unf_ev_s, ctrl_wr_s;
  logic [ADDR_WIDTH-1:0] addr_ch_s;
  logic [CH_W-1:0]       sel_ch_s;
  logic [1:0]            reg_s;
  logic                  ch_ok_s;
  logic [DATA_WIDTH-1:0] rd_mux_s, readdata_r;
  logic                  readdatavalid_r;
  logic                  unused_ok_s;

  // Address decode and per-channel push/pop/flush qualification.
  always_comb begin
    addr_ch_s    = avs_address >> 2;
    reg_s        = avs_address[1:0];
    ch_ok_s      = (32'(addr_ch_s) < CHANNELS);
    sel_ch_s     = addr_ch_s[CH_W-1:0];
    core_rx_data = {(CHANNELS*DATA_WIDTH){1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      ch_sel_s[c]    = ch_ok_s && (sel_ch_s == CH_W'(c));
      h2c_empty_s[c] = (h2c_cnt_r[c] == CNT_W'(0));
      h2c_full_s[c]  = (h2c_cnt_r[c] == CNT_W'(DEPTH));
      c2h_empty_s[c] = (c2h_cnt_r[c] == CNT_W'(0));
      c2h_full_s[c]  = (c2h_cnt_r[c] == CNT_W'(DEPTH));
      h2c_push_s[c]  = ch_sel_s[c] && avs_write && (reg_s == 2'd0) && !h2c_full_s[c];
      ovf_ev_s[c]    = ch_sel_s[c] && avs_write && (reg_s == 2'd0) && h2c_full_s[c];
      h2c_pop_s[c]   = core_rx_ready[c] && !h2c_empty_s[c];
      c2h_push_s[c]  = core_tx_valid[c] && !c2h_full_s[c];
      c2h_pop_s[c]   = ch_sel_s[c] && avs_read && (reg_s == 2'd1) && !c2h_empty_s[c];
      unf_ev_s[c]    = ch_sel_s[c] && avs_read && (reg_s == 2'd1) && c2h_empty_s[c];
      ctrl_wr_s[c]   = ch_sel_s[c] && avs_write && (reg_s == 2'd3);
      h2c_flush_s[c] = ctrl_wr_s[c] && avs_writedata[0];
      c2h_flush_s[c] = ctrl_wr_s[c] && avs_writedata[1];
      clr_s[c]       = ctrl_wr_s[c] && avs_writedata[2];
      core_rx_data[c*DATA_WIDTH +: DATA_WIDTH] = h2c_mem_r[c][h2c_rp_r[c]];
    end
  end

  assign core_rx_valid = ~h2c_empty_s;
  assign core_tx_ready = ~c2h_full_s;

  // FIFO storage; contents survive reset by design.
  always_ff @(posedge clk_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (h2c_push_s[c] && !h2c_flush_s[c])
        h2c_mem_r[c][h2c_wp_r[c]] <= avs_writedata;
      if (c2h_push_s[c] && !c2h_flush_s[c])
        c2h_mem_r[c][c2h_wp_r[c]] <= core_tx_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pointers, counts and sticky flags; flush beats push/pop, events beat clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        h2c_wp_r[c]  <= PTR_W'(0);
        h2c_rp_r[c]  <= PTR_W'(0);
        h2c_cnt_r[c] <= CNT_W'(0);
        c2h_wp_r[c]  <= PTR_W'(0);
        c2h_rp_r[c]  <= PTR_W'(0);
        c2h_cnt_r[c] <= CNT_W'(0);
      end
      ovf_r <= {CHANNELS{1'b0}};
      unf_r <= {CHANNELS{1'b0}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (h2c_flush_s[c]) begin
          h2c_wp_r[c]  <= PTR_W'(0);
          h2c_rp_r[c]  <= PTR_W'(0);
          h2c_cnt_r[c] <= CNT_W'(0);
        end else begin
          if (h2c_push_s[c]) h2c_wp_r[c] <= h2c_wp_r[c] + PTR_W'(1);
          if (h2c_pop_s[c])  h2c_rp_r[c] <= h2c_rp_r[c] + PTR_W'(1);
          case ({h2c_push_s[c], h2c_pop_s[c]})
            2'b10:   h2c_cnt_r[c] <= h2c_cnt_r[c] + CNT_W'(1);
            2'b01:   h2c_cnt_r[c] <= h2c_cnt_r[c] - CNT_W'(1);
            default: h2c_cnt_r[c] <= h2c_cnt_r[c];
          endcase
        end
        if (c2h_flush_s[c]) begin
          c2h_wp_r[c]  <= PTR_W'(0);
          c2h_rp_r[c]  <= PTR_W'(0);
          c2h_cnt_r[c] <= CNT_W'(0);
        end else begin
          if (c2h_push_s[c]) c2h_wp_r[c] <= c2h_wp_r[c] + PTR_W'(1);
          if (c2h_pop_s[c])  c2h_rp_r[c] <= c2h_rp_r[c] + PTR_W'(1);
          case ({c2h_push_s[c], c2h_pop_s[c]})
            2'b10:   c2h_cnt_r[c] <= c2h_cnt_r[c] + CNT_W'(1);
            2'b01:   c2h_cnt_r[c] <= c2h_cnt_r[c] - CNT_W'(1);
            default: c2h_cnt_r[c] <= c2h_cnt_r[c];
          endcase
        end
        if (ovf_ev_s[c])   ovf_r[c] <= 1'b1;
        else if (clr_s[c]) ovf_r[c] <= 1'b0;
        if (unf_ev_s[c])   unf_r[c] <= 1'b1;
        else if (clr_s[c]) unf_r[c] <= 1'b0;
      end
    end
  end

  // Host read mux; out-of-range channels and write-only registers read as zero.
  always_comb begin
    rd_mux_s = {DATA_WIDTH{1'b0}};
    if (avs_read && ch_ok_s) begin
      case (reg_s)
        2'd1: begin
          if (!c2h_empty_s[sel_ch_s]) rd_mux_s = c2h_mem_r[sel_ch_s][c2h_rp_r[sel_ch_s]];
          else                        rd_mux_s = {DATA_WIDTH{1'b0}};
        end
        2'd2: rd_mux_s = DATA_WIDTH'({8'd0, sat8(h2c_cnt_r[sel_ch_s]), sat8(c2h_cnt_r[sel_ch_s]),
                                      2'b00, unf_r[sel_ch_s], ovf_r[sel_ch_s],
                                      c2h_full_s[sel_ch_s], c2h_empty_s[sel_ch_s],
                                      h2c_full_s[sel_ch_s], h2c_empty_s[sel_ch_s]});
        2'd3: rd_mux_s = DATA_WIDTH'({23'd0, irq_en_s[sel_ch_s], 8'd0});
        default: rd_mux_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rd_mux_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Fixed read latency of one cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_r      <= {DATA_WIDTH{1'b0}};
      readdatavalid_r <= 1'b0;
    end else begin
      readdata_r      <= rd_mux_s;
      readdatavalid_r <= avs_read;
    end
  end

  assign avs_readdata      = readdata_r;
  assign avs_readdatavalid = readdatavalid_r;

`ifdef HPS_MBOX_IRQ_EN
  logic [CHANNELS-1:0] irq_en_r;
  logic                irq_r;

  // Interrupt enables and the level interrupt derived from registered FIFO state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en_r <= {CHANNELS{1'b0}};
      irq_r    <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ctrl_wr_s[c]) irq_en_r[c] <= avs_writedata[8];
      end
      irq_r <= |(irq_en_r & ~c2h_empty_s);
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign irq_en_s = {CHANNELS{1'b0}};
  assign irq      = 1'b0;
`endif

  assign unused_ok_s = ^avs_writedata;

endmodule

// File: tb/tb_hps_avmm_mailbox.sv
// Self-checking bench for hps_avmm_mailbox: directed plan plus randomized traffic
// against a queue-based model of the mailbox.
module tb_hps_avmm_mailbox;

  localparam int CH = 2;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_readdatavalid;
  logic [63:0] core_rx_data, core_tx_data;
  logic [1:0]  core_rx_valid, core_rx_ready, core_tx_valid, core_tx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  hps_avmm_mailbox #(.DATA_WIDTH(32), .CHANNELS(CH), .DEPTH(DEP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per FIFO plus sticky flags and enables.
  logic [31:0] h2c_q [CH][$];
  logic [31:0] c2h_q [CH][$];
  bit          ovf [CH];
  bit          unf [CH];
  bit          irq_en [CH];
  bit          exp_rdv;
  logic [31:0] exp_rd;
  bit          exp_irq;

  function automatic logic [31:0] status_of(input int c);
    int hs = h2c_q[c].size();
    int cs = c2h_q[c].size();
    return 32'((hs << 16) | (cs << 8) | (int'(unf[c]) << 5) | (int'(ovf[c]) << 4) |
               (int'(cs == DEP) << 3) | (int'(cs == 0) << 2) |
               (int'(hs == DEP) << 1) | int'(hs == 0));
  endfunction

  // Model update at each active edge, then compare outputs 1 time unit later.
  initial begin
    logic        r, w, rn;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [1:0]  rr, tv;
    logic [63:0] td;
    int          ch, rg, hpre, cpre;
    bit          irq_next;
    forever begin
      @(posedge clk);
      r = avs_read; w = avs_write; a = avs_address; wd = avs_writedata;
      rr = core_rx_ready; tv = core_tx_valid; td = core_tx_data; rn = rst_n;
      #1;
      if (!rn) begin
        for (int c = 0; c < CH; c++) begin
          h2c_q[c].delete(); c2h_q[c].delete();
          ovf[c] = 0; unf[c] = 0; irq_en[c] = 0;
        end
        exp_rdv = 0; exp_irq = 0;
      end else begin
        ch = int'(a) >> 2;
        rg = int'(a) & 3;
        irq_next = 0;
        for (int c = 0; c < CH; c++) if (irq_en[c] && c2h_q[c].size() > 0) irq_next = 1;
        exp_rdv = r;
        exp_rd  = 32'd0;
        if (r) begin
          if (rg == 1 && c2h_q[ch].size() > 0) exp_rd = c2h_q[ch][0];
          else if (rg == 2) exp_rd = status_of(ch);
`ifdef HPS_MBOX_IRQ_EN
          else if (rg == 3) exp_rd = irq_en[ch] ? 32'h100 : 32'h0;
`endif
        end
        for (int c = 0; c < CH; c++) begin
          hpre = h2c_q[c].size();
          cpre = c2h_q[c].size();
          if (w && ch == c && rg == 3 && wd[2]) begin ovf[c] = 0; unf[c] = 0; end
          if (w && ch == c && rg == 3) irq_en[c] = wd[8];
          if (w && ch == c && rg == 3 && wd[0]) h2c_q[c].delete();
          else begin
            if (rr[c] && hpre > 0) void'(h2c_q[c].pop_front());
            if (w && ch == c && rg == 0) begin
              if (hpre < DEP) h2c_q[c].push_back(wd);
              else ovf[c] = 1;
            end
          end
          if (w && ch == c && rg == 3 && wd[1]) c2h_q[c].delete();
          else begin
            if (r && ch == c && rg == 1) begin
              if (cpre > 0) void'(c2h_q[c].pop_front());
              else unf[c] = 1;
            end
            if (tv[c] && cpre < DEP) c2h_q[c].push_back(td[c*32 +: 32]);
          end
        end
        exp_irq = irq_next;
      end
      if (rst_n) begin
        chk("readdatavalid", avs_readdatavalid, exp_rdv);
        if (exp_rdv) chk("readdata", avs_readdata, exp_rd);
        for (int c = 0; c < CH; c++) begin
          chk("rx_valid", core_rx_valid[c], h2c_q[c].size() > 0);
          if (h2c_q[c].size() > 0) chk("rx_data", core_rx_data[c*32 +: 32], h2c_q[c][0]);
          chk("tx_ready", core_tx_ready[c], c2h_q[c].size() < DEP);
        end
`ifdef HPS_MBOX_IRQ_EN
        chk("irq", irq, exp_irq);
`else
        chk("irq_tied", irq, 1'b0);
`endif
      end else begin
        chk("rst_tx_ready", core_tx_ready, 2'b11);
        chk("rst_rx_valid", core_rx_valid, 2'b00);
        chk("rst_rdv", avs_readdatavalid, 1'b0);
        chk("rst_irq", irq, 1'b0);
      end
    end
  end

  task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; core_rx_ready = 2'b00; core_tx_valid = 2'b00; core_tx_data = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", core_tx_ready, 2'b11);
    chk("reset_rdv", avs_readdatavalid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    host_read(3'b010, v);
    chk("status_after_reset", v, 32'h0000_0005);

    host_write(3'b100, 32'hDEAD_BEEF);
    host_write(3'b100, 32'h1234_5678);
    chk("ch1_rx_valid", core_rx_valid[1], 1'b1);
    chk("ch1_rx_head", core_rx_data[63:32], 32'hDEAD_BEEF);
    core_rx_ready = 2'b10;
    @(negedge clk);
    chk("ch1_rx_second", core_rx_data[63:32], 32'h1234_5678);
    @(negedge clk);
    core_rx_ready = 2'b00;
    chk("ch1_rx_drained", core_rx_valid[1], 1'b0);

    for (int i = 0; i < 17; i++) begin
      core_tx_valid = 2'b01; core_tx_data = 64'(i);
      @(negedge clk);
      if (i == 15) chk("c2h_full_ready", core_tx_ready[0], 1'b0);
    end
    core_tx_valid = 2'b00;
    host_read(3'b010, v);
    chk("status_c2h_full", v, 32'h0000_1009);
    for (int i = 0; i < 16; i++) begin
      host_read(3'b001, v);
      chk("c2h_order", v, 32'(i));
    end
    host_read(3'b001, v);
    chk("c2h_underflow_data", v, 32'h0);
    host_read(3'b010, v);
    chk("status_underflow", v, 32'h0000_0025);

    for (int i = 0; i < 16; i++) host_write(3'b000, 32'h100 + 32'(i));
    host_write(3'b000, 32'h0000_00AA);
    for (int i = 0; i < 3; i++) begin
      core_tx_valid = 2'b01; core_tx_data = 64'(32'h200 + 32'(i));
      @(negedge clk);
    end
    core_tx_valid = 2'b00;
    host_read(3'b010, v);
    chk("status_overflow", v, 32'h0010_0332);
    host_write(3'b011, 32'h5);
    host_read(3'b010, v);
    chk("status_after_flush", v, 32'h0000_0301);

    for (int i = 3; i < 8; i++) begin
      core_tx_valid = 2'b01; core_tx_data = 64'(32'h200 + 32'(i));
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      avs_address = 3'b001; avs_read = 1'b1;
      core_tx_valid = 2'b01; core_tx_data = 64'(32'h300 + 32'(i));
      @(negedge clk);
      chk("simul_order", avs_readdata, (i < 8) ? 32'h200 + 32'(i) : 32'h300 + 32'(i - 8));
    end
    avs_read = 1'b0; core_tx_valid = 2'b00;
    host_read(3'b010, v);
    chk("status_simul", v, 32'h0000_0801);

    host_write(3'b111, 32'h100);
    host_read(3'b111, v);
`ifdef HPS_MBOX_IRQ_EN
    chk("ctrl_readback", v, 32'h100);
    core_tx_valid = 2'b10; core_tx_data = 64'hCAFE_0001_0000_0000;
    @(negedge clk);
    core_tx_valid = 2'b00;
    chk("irq_not_yet", irq, 1'b0);
    @(negedge clk);
    chk("irq_set", irq, 1'b1);
    host_read(3'b101, v);
    chk("irq_pop_data", v, 32'hCAFE_0001);
    chk("irq_still_high", irq, 1'b1);
    @(negedge clk);
    chk("irq_cleared", irq, 1'b0);
`else
    chk("ctrl_readback_noirq", v, 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        avs_read = 1'b0; avs_write = 1'b0; core_tx_valid = 2'b00; core_rx_ready = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      avs_address   = 3'($urandom_range(0, 7));
      avs_writedata = $urandom;
      if ($urandom_range(0, 7) != 0) avs_writedata[1:0] = 2'b00;
      case ($urandom_range(0, 3))
        1: begin avs_read = 1'b1; avs_write = 1'b0; end
        2: begin avs_read = 1'b0; avs_write = 1'b1; end
        default: begin avs_read = 1'b0; avs_write = 1'b0; end
      endcase
      core_rx_ready = 2'($urandom) & 2'($urandom);
      core_tx_valid = 2'($urandom);
      core_tx_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    avs_read = 1'b0; avs_write = 1'b0; core_tx_valid = 2'b00; core_rx_ready = 2'b00;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
